seq_tx: RTL and testbench

Serial transmitter for 16-bit pattern words, the sending end of the pattern-count path. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, with a frame strobe. While shifting, it counts overlapping `101` occurrences in the transmitted stream, so the receiving side's parallel count can be checked against the count the transmitter reports.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_tx_if.sv | 15 +
 rtl/seq_match_cnt.sv | 49 ++++
 rtl/seq_tx.sv | 102 ++++++++++
 tb/tb_seq_tx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the pattern-count serial path (transmitter and receiver).
package seq_pkg;

  localparam int unsigned SEQ_WIDTH   = 16;
  localparam int unsigned SEQ_CNT_W   = 3;
  localparam logic [2:0]  SEQ_PATTERN = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_tx_state_t;

endpackage

// File: rtl/seq_tx_if.sv
// Parallel word handshake into seq_tx: source drives din/in_valid, transmitter drives in_ready.
interface seq_tx_if
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             in_ready;

  modport master (output din, output in_valid, input in_ready);
  modport slave  (input din, input in_valid, output in_ready);

endinterface

// File: rtl/seq_match_cnt.sv
// Counts overlapping SEQ_PATTERN occurrences in a bit stream; shared by transmitter and receiver.
module seq_match_cnt
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] cnt
);

  // Only the two most recent bits are stored; the third is the incoming bit itself.
  logic [1:0]       r_hist;
  logic [1:0]       r_seen;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_hist;
  logic             w_hit;

  always_comb begin
    w_hist = {r_hist, bit_in};
    w_hit  = (r_seen == 2'd2) && (w_hist == SEQ_PATTERN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_seen <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_seen <= '0;
      r_cnt  <= '0;
    end else if (bit_en) begin
      r_hist <= w_hist[1:0];
      if (r_seen != 2'd2) begin
        r_seen <= r_seen + 2'd1;
      end
      if (w_hit) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_tx.sv
// MSB-first serial transmitter with frame strobe and done pulse.
// Define SEQ_TX_CNT_EN to include the overlapping 101 match counter on the count output.
module seq_tx
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH,
  parameter int unsigned CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_tx_if.slave          s_in,
  output logic             sout,
  output logic             sframe,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  seq_tx_state_t    r_state;
  seq_tx_state_t    w_next;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-2:0] r_sh;
  logic             r_sout;
  logic             r_sframe;
  logic             r_done;
  logic             r_in_ready;
  logic             w_accept;
  logic             w_last;

  always_comb begin
    w_accept = r_in_ready & s_in.in_valid;
    w_last   = (r_idx == IDX_W'(WIDTH - 1));
    w_next   = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // r_sout is the top stage of the shift register, so r_sh holds only the remaining WIDTH-1 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_sh       <= '0;
      r_sout     <= 1'b0;
      r_sframe   <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_sframe   <= (w_next == SHIFT);
      r_done     <= (w_next == DONE);
      r_in_ready <= (w_next == IDLE);
      if (w_accept) begin
        r_sh   <= s_in.din[WIDTH-2:0];
        r_sout <= s_in.din[WIDTH-1];
        r_idx  <= '0;
      end else if (r_state == SHIFT) begin
        r_idx  <= r_idx + IDX_W'(1);
        r_sout <= w_last ? 1'b0 : r_sh[WIDTH-2];
        r_sh   <= {r_sh[WIDTH-3:0], 1'b0};
      end else begin
        r_sout <= 1'b0;
      end
    end
  end

  assign sout          = r_sout;
  assign sframe        = r_sframe;
  assign done          = r_done;
  assign s_in.in_ready = r_in_ready;

`ifdef SEQ_TX_CNT_EN
  logic [CNT_W-1:0] w_cnt;

  seq_match_cnt #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .bit_en(r_sframe),
    .bit_in(r_sout),
    .cnt   (w_cnt)
  );

  assign count = w_cnt;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx plus a direct check of the shared seq_match_cnt block.
module tb_seq_tx;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 3;
`ifdef SEQ_TX_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sout, sframe, done;
  logic [CW-1:0] count;

  seq_tx_if #(.WIDTH(W)) bus ();

  seq_tx #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_in  (bus),
    .sout  (sout),
    .sframe(sframe),
    .done  (done),
    .count (count)
  );

  logic          mc_clr = 1'b0;
  logic          mc_en = 1'b0;
  logic          mc_bit = 1'b0;
  logic [CW-1:0] mc_cnt;

  seq_match_cnt #(
    .CNT_W(CW)
  ) u_mc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mc_clr),
    .bit_en(mc_en),
    .bit_in(mc_bit),
    .cnt   (mc_cnt)
  );

  always #5 clk = ~clk;

  int unsigned   n_cmp = 0;
  int unsigned   n_fail = 0;
  logic [3:0]    exp_q[$];
  logic [CW-1:0] cnt_q[$];

  // Overlapping 101 windows over the MSB-first bit order.
  function automatic int unsigned count101(input logic [15:0] w);
    int unsigned c = 0;
    for (int k = 2; k < 16; k++) begin
      if (w[17-k] == 1'b1 && w[16-k] == 1'b0 && w[15-k] == 1'b1) c++;
    end
    return c;
  endfunction

  // Expected {sframe, sout, done, in_ready} for the 18 cycles after an accept.
  task automatic push_word(input logic [15:0] w);
    int unsigned c;
    for (int m = 1; m <= 18; m++) begin
      if (m <= 16) exp_q.push_back({1'b1, w[16-m], 2'b00});
      else if (m == 17) exp_q.push_back(4'b0010);
      else exp_q.push_back(4'b0001);
    end
    c = CNT_EN ? count101(w) : 0;
    cnt_q.push_back(CW'(c));
  endtask

  task automatic test_words(input logic [15:0] w0, input logic [15:0] w1,
                            input int unsigned nw, input bit toggle, input string nm);
    int unsigned t;
    int unsigned m;
    logic [3:0]    e, obs;
    logic [CW-1:0] ec;
    ec = '0;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: in_ready=%b required 1", nm, bus.in_ready);
    end
    push_word(w0);
    if (nw == 2) push_word(w1);
    bus.din      = w0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din = (nw == 2) ? w1 : ~w0;
    if (nw != 2 && !toggle) bus.in_valid = 1'b0;
    for (int n = 1; n <= 18 * int'(nw); n++) begin
      @(negedge clk);
      m   = (n - 1) % 18 + 1;
      obs = {sframe, sout, done, bus.in_ready};
      e   = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s cyc%0d: {sframe,sout,done,in_ready}=%b required %b", nm, n, obs, e);
      end
      if (m == 17) begin
        ec = cnt_q.pop_front();
        n_cmp++;
        if (count !== ec) begin
          n_fail++;
          $display("FAIL %s count_done: count=%0d required %0d", nm, count, ec);
        end
      end
      if (m == 18) begin
        n_cmp++;
        if (count !== ec) begin
          n_fail++;
          $display("FAIL %s count_held: count=%0d required %0d", nm, count, ec);
        end
      end
      if (toggle && n < 16) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.din      = 16'($urandom);
      end else if (toggle) begin
        bus.in_valid = 1'b0;
      end
      if (nw == 2 && n == 19) bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.din      = '0;
    repeat (2) @(negedge clk);
    obs = {sframe, sout, done, bus.in_ready};
    n_cmp++;
    if (obs !== 4'b0001 || count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: {sframe,sout,done,in_ready}=%b count=%0d required 0001 count=0", obs, count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs = {sframe, sout, done, bus.in_ready};
    n_cmp++;
    if (obs !== 4'b0001 || count !== '0) begin
      n_fail++;
      $display("FAIL reset_release: {sframe,sout,done,in_ready}=%b count=%0d required 0001 count=0", obs, count);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] pats[6];
    pats = '{16'b1010000000000101, 16'b1011011011010101, 16'h0000,
             16'hAAAA, 16'h5555, 16'hFFFF};
    foreach (pats[i]) test_words(pats[i], 16'h0000, 1, 1'b0, $sformatf("pat_%h", pats[i]));
    test_words(16'b1011011011010101, 16'h0000, 1, 1'b1, "valid_toggle");
  endtask

  task automatic test_back_to_back();
    test_words(16'b1010000000000101, 16'h5555, 2, 1'b0, "b2b_a005_5555");
    test_words(16'hAAAA, 16'hB6D5, 2, 1'b0, "b2b_aaaa_b6d5");
  endtask

  task automatic test_reset_mid_shift();
    logic [3:0] obs;
    @(negedge clk);
    bus.din      = 16'hAAAA;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (sframe !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid pre_sframe: sframe=%b required 1", sframe);
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {sframe, sout, done, bus.in_ready};
    n_cmp++;
    if (obs !== 4'b0001 || count !== '0) begin
      n_fail++;
      $display("FAIL rst_mid async: {sframe,sout,done,in_ready}=%b count=%0d required 0001 count=0", obs, count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      obs = {sframe, sout, done, bus.in_ready};
      n_cmp++;
      if (obs !== 4'b0001) begin
        n_fail++;
        $display("FAIL rst_mid idle%0d: {sframe,sout,done,in_ready}=%b required 0001", n, obs);
      end
    end
    test_words(16'b1010000000000101, 16'h0000, 1, 1'b0, "after_reset");
  endtask

  task automatic test_match_cnt();
    logic [15:0] words[6];
    logic [CW-1:0] ec;
    words = '{16'b1010000000000101, 16'hAAAA, 16'h5555,
              16'($urandom), 16'($urandom), 16'($urandom)};
    foreach (words[i]) begin
      @(negedge clk);
      mc_clr = 1'b1;
      @(negedge clk);
      mc_clr = 1'b0;
      n_cmp++;
      if (mc_cnt !== '0) begin
        n_fail++;
        $display("FAIL mc_clr_%h: cnt=%0d required 0", words[i], mc_cnt);
      end
      for (int k = 15; k >= 0; k--) begin
        mc_bit = words[i][k];
        mc_en  = 1'b1;
        @(negedge clk);
        mc_en  = 1'b0;
        mc_bit = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      ec = CW'(count101(words[i]));
      n_cmp++;
      if (mc_cnt !== ec) begin
        n_fail++;
        $display("FAIL mc_cnt_%h: cnt=%0d required %0d", words[i], mc_cnt, ec);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_patterns();
    test_back_to_back();
    test_reset_mid_shift();
    test_match_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
